// File: rtl/seg7_scan_if.sv
// seg7_scan_if: valid/ready load bundle carrying one nibble per digit.
interface seg7_scan_if #(parameter int NUM_DIGITS = 4);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    modport master (output load_valid, output load_data, input load_ready);
    modport slave (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-seg scanner with blank guard and frame-aligned loads.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    seg7_scan_if.slave            ld,
    output logic [3:0]            dec_in,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);
    localparam int CMAX = DIV > BLANK_CYC ? DIV : BLANK_CYC;
    localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DIV_T = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_T = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx, idx_next;
    logic [NUM_DIGITS-1:0][3:0] display, shadow, disp_next;
    logic                       pending, wrap, commit, lit;

    assign ld.load_ready = ~pending;
    assign wrap = enable && state == SHOW && cnt == DIV_T && idx == LAST;
    // In OFF no frame is in flight, so a pending value can land immediately.
    assign commit = pending && (state == OFF || wrap);
    assign disp_next = commit ? shadow : display;
    assign idx_next = idx == LAST ? '0 : idx + 1'b1;

`ifdef SEG7_LZ_BLANK_EN
    logic [IW-1:0] lz_max;

    function automatic logic [IW-1:0] top_digit(input logic [NUM_DIGITS-1:0][3:0] v);
        top_digit = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (v[i] != 4'h0) top_digit = IW'(i);
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst) lz_max <= '0;
        else if (commit) lz_max <= top_digit(shadow);

    assign lit = idx <= lz_max;
`else
    assign lit = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            idx        <= '0;
            cnt        <= '0;
            seg        <= 7'h7F;
            an         <= '1;
            dec_in     <= 4'h0;
            frame_done <= 1'b0;
            display    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (ld.load_valid && !pending) begin
                shadow  <= ld.load_data;
                pending <= 1'b1;
            end
            if (commit) begin
                display <= shadow;
                pending <= 1'b0;
            end
            if (!enable) begin
                state  <= OFF;
                idx    <= '0;
                cnt    <= '0;
                seg    <= 7'h7F;
                an     <= '1;
                dec_in <= 4'h0;
            end else begin
                case (state)
                    OFF: begin
                        state  <= BLANK;
                        idx    <= '0;
                        cnt    <= '0;
                        dec_in <= disp_next[0];
                    end
                    BLANK: begin
                        cnt <= cnt == BLANK_T ? '0 : cnt + 1'b1;
                        if (cnt == BLANK_T) begin
                            state <= SHOW;
                            an    <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
                            seg   <= lit ? dec_seg : 7'h7F;
                        end
                    end
                    default: begin
                        cnt <= cnt == DIV_T ? '0 : cnt + 1'b1;
                        seg <= cnt != DIV_T && lit ? dec_seg : 7'h7F;
                        if (cnt == DIV_T) begin
                            state      <= BLANK;
                            an         <= '1;
                            idx        <= idx_next;
                            dec_in     <= disp_next[idx_next];
                            frame_done <= idx == LAST;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench against a time-position model of the scan.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
    localparam int N = 4, DIV = 4, BLK = 2, SLOT = DIV + BLK, FRAME = N * SLOT;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [3:0] dec_in;
    logic [6:0] dec_seg, seg;
    logic [3:0] an;
    logic       frame_done;
    logic [16:0] got, exp_v;
    int n_checks = 0, n_fail = 0;

    bit          m_on, m_pend;
    int          m_t;
    logic [15:0] m_disp, m_shad;

    seg7_scan_if #(.NUM_DIGITS(N)) lif ();

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk(clk), .rst(rst), .enable(en), .ld(lif), .dec_in(dec_in),
        .dec_seg(dec_seg), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    assign dec_seg = hex7(dec_in);
    assign got = {an, seg, dec_in, frame_done, lif.load_ready};

`ifdef SEG7_LZ_BLANK_EN
    function automatic int hi_digit(input logic [15:0] v);
        int h = 0;
        for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'h0) h = i;
        return h;
    endfunction
`endif

    // Expected outputs follow purely from the position within the frame.
    task automatic compute_exp();
        int p, d;
        bit lit;
        logic [3:0] nib;
        if (!m_on) begin
            exp_v = {4'hF, 7'h7F, 4'h0, 1'b0, !m_pend};
        end else begin
            p = m_t % FRAME;
            d = p / SLOT;
            lit = (p % SLOT) >= BLK;
`ifdef SEG7_LZ_BLANK_EN
            lit = lit && d <= hi_digit(m_disp);
`endif
            nib = m_disp[4*d +: 4];
            exp_v = {lit ? ~(4'b1 << d) : 4'hF, lit ? hex7(nib) : 7'h7F, nib,
                     m_t > 0 && p == 0, !m_pend};
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_pend = 0; m_t = 0; m_disp = '0; m_shad = '0;
        compute_exp();
    endtask

    task automatic tick();
        bit xfer;
        @(posedge clk);
        xfer = lif.load_valid && !m_pend;
        if (rst) begin
            m_on = 0; m_pend = 0; m_t = 0; m_disp = '0; m_shad = '0;
        end else begin
            if (m_on && en) begin
                m_t++;
                if (m_pend && m_t % FRAME == 0) begin m_disp = m_shad; m_pend = 0; end
            end else if (m_on) begin
                m_on = 0;
            end else begin
                if (m_pend) begin m_disp = m_shad; m_pend = 0; end
                if (en) begin m_on = 1; m_t = 0; end
            end
            if (xfer) begin m_shad = lif.load_data; m_pend = 1; end
        end
        #1;
        compute_exp();
    endtask

    task automatic test_reset();
        rst = 1; en = 0; lif.load_valid = 0; lif.load_data = '0;
        model_reset();
        tick(); tick();
        n_checks++;
        if (got !== {4'hF, 7'h7F, 4'h0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", got, {4'hF, 7'h7F, 4'h0, 1'b0, 1'b1});
        end
        rst = 0;
        tick();
        n_checks++;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_load_scan();
        lif.load_valid = 1; lif.load_data = 16'h1234;
        tick();
        lif.load_valid = 0;
        n_checks++;
        if (lif.load_ready !== 1'b0) begin n_fail++; $display("FAIL off_load_pending ready=%b exp=0", lif.load_ready); end
        tick();
        n_checks++;
        if (lif.load_ready !== 1'b1) begin n_fail++; $display("FAIL off_commit ready=%b exp=1", lif.load_ready); end
        en = 1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL scan c=%0d got=%h exp=%h", c, got, exp_v); end
            if (c == 0) begin
                n_checks++;
                if (dec_in !== 4'h4) begin n_fail++; $display("FAIL first_dec got=%h exp=4", dec_in); end
            end
            if (c == 2) begin
                n_checks++;
                if ({an, seg} !== {4'b1110, 7'b0011001}) begin n_fail++; $display("FAIL digit0 got=%b_%b exp=1110_0011001", an, seg); end
            end
            if (c == 8) begin
                n_checks++;
                if ({an, seg} !== {4'b1101, 7'b0110000}) begin n_fail++; $display("FAIL digit1 got=%b_%b exp=1101_0110000", an, seg); end
            end
        end
    endtask

    task automatic test_frame_timing();
        int last = -1, pulses = 0;
        logic prev_fd = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            n_checks++;
            if ($countones(~an) > 1 || got !== exp_v) begin
                n_fail++; $display("FAIL frame_cycle c=%0d got=%h exp=%h", c, got, exp_v);
            end
            if (frame_done) begin
                n_checks++;
                if (prev_fd || (last >= 0 && c - last != FRAME) || dec_in !== 4'h4) begin
                    n_fail++; $display("FAIL frame_pulse c=%0d gap=%0d prev=%b dec=%h exp gap=%0d", c, c - last, prev_fd, dec_in, FRAME);
                end
                last = c; pulses++;
            end
            prev_fd = frame_done;
        end
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL frame_count got=%0d exp=3", pulses); end
    endtask

    task automatic test_handshake();
        int wraps = 0;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 10; k++) tick();
        lif.load_valid = 1; lif.load_data = 16'hABCD;
        tick();
        lif.load_data = 16'h5678;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL handshake c=%0d got=%h exp=%h", c, got, exp_v); end
            if (m_t % FRAME == 0) begin
                wraps++;
                n_checks++;
                if ((wraps == 1 && dec_in !== 4'hD) || (wraps == 2 && dec_in !== 4'h8)) begin
                    n_fail++; $display("FAIL wrap_commit wrap=%0d dec=%h", wraps, dec_in);
                end
            end else if (wraps == 0) begin
                n_checks++;
                if (lif.load_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c=%0d ready=%b exp=0", c, lif.load_ready); end
            end
        end
        lif.load_valid = 0;
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < FRAME && (m_t % FRAME) != 2 * SLOT + BLK + 1; k++) tick();
        en = 0;
        tick();
        n_checks++;
        if ({an, seg} !== {4'hF, 7'h7F} || got !== exp_v) begin
            n_fail++; $display("FAIL enable_drop got=%h exp=%h", got, exp_v);
        end
        tick(); tick();
        en = 1;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp_v); end
            if (c == BLK) begin
                n_checks++;
                if (an !== 4'b1110) begin n_fail++; $display("FAIL restart_digit0 an=%b exp=1110", an); end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        for (int k = 0; k < FRAME && (m_t % FRAME) != SLOT + BLK + 1; k++) tick();
        #3 rst = 1;
        #1;
        model_reset();
        n_checks++;
        if ({an, seg, frame_done, lif.load_ready} !== {4'hF, 7'h7F, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset got an=%b seg=%h fd=%b rdy=%b", an, seg, frame_done, lif.load_ready);
        end
        tick(); tick(); tick();
        rst = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, got, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            lif.load_valid = $urandom_range(0, 3) == 0;
            lif.load_data = 16'($urandom);
            en = $urandom_range(0, 79) != 0;
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp_v); end
        end
        lif.load_valid = 0; en = 1;
    endtask

    task automatic load_and_settle(input logic [15:0] v);
        lif.load_valid = 1; lif.load_data = v;
        for (int k = 0; k < 2 * FRAME && !(m_pend && m_shad == v); k++) tick();
        lif.load_valid = 0;
        for (int k = 0; k < 2 * FRAME && m_pend; k++) tick();
    endtask

    task automatic test_digit_gating();
        bit lit3 = 0;
        load_and_settle(16'h0050);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            n_checks++;
            if (got !== exp_v) begin n_fail++; $display("FAIL gating c=%0d got=%h exp=%h", c, got, exp_v); end
            lit3 |= !an[3];
`ifdef SEG7_LZ_BLANK_EN
            n_checks++;
            if (an[3:2] !== 2'b11) begin n_fail++; $display("FAIL lz_upper c=%0d an=%b exp=11xx", c, an); end
`endif
        end
        n_checks++;
`ifdef SEG7_LZ_BLANK_EN
        if (lit3) begin n_fail++; $display("FAIL lz_digit3 lit=%b exp=0", lit3); end
        load_and_settle(16'h0000);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            n_checks++;
            if (an[3:1] !== 3'b111 || (!an[0] && seg !== 7'b1000000) || got !== exp_v) begin
                n_fail++; $display("FAIL lz_zero c=%0d got=%h exp=%h", c, got, exp_v);
            end
        end
`else
        if (!lit3) begin n_fail++; $display("FAIL all_lit digit3 lit=%b exp=1", lit3); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_frame_timing();
        test_handshake();
        test_enable_drop();
        test_reset_mid_show();
        test_random();
        test_digit_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
